// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared encodings for the accumulator-processor sequencer:
//   opcode values, ALU operation codes and the sequencer state enum.
package control_unit_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_NOP = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_LDA = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_STA = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_SUB = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_JMP = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_ADDR = 3'd1,
        F_READ = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Opcodes that need a second memory access in EXEC.
    function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// control_unit_decode
//   Combinational next-state and strobe decoder for the sequencer.
//   Ports:
//     state_q   current state
//     ir_op     live opcode from the IR (meaningful in DECODE only)
//     op_q      registered opcode copy used in EXEC
//     run, zero, mem_ack   control inputs
//     state_d   next state
//     hir..halted          datapath / memory strobes
//     retire    high in the cycle whose closing edge retires an instruction
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | waiting for RUN, all strobes low
//   F_ADDR | load MAR from PC
//   F_READ | instruction read; on ack load IR and bump PC
//   DECODE | act on IR opcode: jump, halt, or set up operand
//   EXEC   | operand read/write; on ack load ACC (not STA)
//   HALT   | HALTED high, sticky until reset
module control_unit_decode
    import control_unit_pkg::*;
(
    input  state_t                state_q,
    input  logic [OPCODE_W-1:0]   ir_op,
    input  logic [OPCODE_W-1:0]   op_q,
    input  logic                  run,
    input  logic                  zero,
    input  logic                  mem_ack,
    output state_t                state_d,
    output logic                  hir,
    output logic                  hpc,
    output logic                  lpc,
    output logic                  sel_mar,
    output logic                  hmar,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  hacc,
    output logic [1:0]            alu_op,
    output logic                  halted,
    output logic                  retire
);

    always_comb begin
        state_d = state_q;
        hir     = 1'b0;
        hpc     = 1'b0;
        lpc     = 1'b0;
        sel_mar = 1'b0;
        hmar    = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        hacc    = 1'b0;
        alu_op  = ALU_PASS;
        halted  = 1'b0;
        retire  = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = F_ADDR;
                end
            end

            F_ADDR: begin
                hmar    = 1'b1;
                state_d = F_READ;
            end

            F_READ: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    hir     = 1'b1;
                    hpc     = 1'b1;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                retire = 1'b1;
                case (ir_op)
                    OP_NOP: state_d = F_ADDR;
                    OP_JMP: begin
                        lpc     = 1'b1;
                        state_d = F_ADDR;
                    end
                    OP_JZ: begin
                        lpc     = zero;
                        state_d = F_ADDR;
                    end
                    OP_HLT: state_d = HALT;
                    default: begin
                        sel_mar = 1'b1;
                        hmar    = 1'b1;
                        state_d = EXEC;
                    end
                endcase
            end

            EXEC: begin
                if (op_q == OP_STA) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                end
                if (mem_ack) begin
                    state_d = F_ADDR;
                    case (op_q)
                        OP_LDA: begin
                            hacc   = 1'b1;
                            alu_op = ALU_PASS;
                        end
                        OP_ADD: begin
                            hacc   = 1'b1;
                            alu_op = ALU_ADD;
                        end
                        OP_SUB: begin
                            hacc   = 1'b1;
                            alu_op = ALU_SUB;
                        end
                        default: ;
                    endcase
                end
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Fetch/decode/execute sequencer for the 8-bit accumulator processor.
//   Ports:
//     CLK, RESET_N      clock, async active-low reset
//     RUN               start request (IDLE only)
//     IR_OP             opcode field from the IR
//     ZERO              accumulator-zero flag
//     MEM_ACK           memory completion
//     HIR, HPC, LPC     IR load, PC increment, PC load
//     SEL_MAR, HMAR     MAR source select and load
//     MEM_RD, MEM_WR    memory requests, held until MEM_ACK
//     HACC, ALU_OP      accumulator load and ALU function
//     HALTED            high in HALT
//     INSTR_COUNT       retired-instruction counter (wraps)
module control_unit
    import control_unit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              RUN,
    input  logic [OP_W-1:0]   IR_OP,
    input  logic              ZERO,
    input  logic              MEM_ACK,
    output logic              HIR,
    output logic              HPC,
    output logic              LPC,
    output logic              SEL_MAR,
    output logic              HMAR,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic              HACC,
    output logic [1:0]        ALU_OP,
    output logic              HALTED,
    output logic [CNT_W-1:0]  INSTR_COUNT
);

    // The opcode table is fixed at three bits and must fit in the data word.
    if (OP_W != OPCODE_W || OP_W > DATA_W) begin : g_param_check
        $fatal(1, "control_unit: OP_W must be 3 and no wider than DATA_W");
    end

    state_t               state_q;
    state_t               state_d;
    logic [OPCODE_W-1:0]  ir_op;
    logic [OPCODE_W-1:0]  op_q;
    logic [OPCODE_W-1:0]  op_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 retire;

    assign ir_op = IR_OP[OPCODE_W-1:0];

    control_unit_decode u_decode (
        .state_q (state_q),
        .ir_op   (ir_op),
        .op_q    (op_q),
        .run     (RUN),
        .zero    (ZERO),
        .mem_ack (MEM_ACK),
        .state_d (state_d),
        .hir     (HIR),
        .hpc     (HPC),
        .lpc     (LPC),
        .sel_mar (SEL_MAR),
        .hmar    (HMAR),
        .mem_rd  (MEM_RD),
        .mem_wr  (MEM_WR),
        .hacc    (HACC),
        .alu_op  (ALU_OP),
        .halted  (HALTED),
        .retire  (retire)
    );

    // The IR is written on the HIR edge, so the new opcode first appears on
    // IR_OP during DECODE. Capturing it there keeps EXEC independent of IR_OP.
    always_comb begin
        op_d = op_q;
        if (state_q == DECODE) begin
            op_d = ir_op;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Self-checking bench for control_unit. Each instruction is expanded into
//   an expected per-cycle strobe trace built from the instruction rules
//   (fetch, decode, optional operand access, wait cycles), then replayed
//   against the DUT with random values on every input the DUT must ignore.
module tb_control_unit;

    localparam int CW = 4;

    // expected strobe vector bit masks
    localparam logic [10:0] M_HIR  = 11'h400;
    localparam logic [10:0] M_HPC  = 11'h200;
    localparam logic [10:0] M_LPC  = 11'h100;
    localparam logic [10:0] M_SEL  = 11'h080;
    localparam logic [10:0] M_HMAR = 11'h040;
    localparam logic [10:0] M_RD   = 11'h020;
    localparam logic [10:0] M_WR   = 11'h010;
    localparam logic [10:0] M_HACC = 11'h008;
    localparam logic [10:0] M_AADD = 11'h002;
    localparam logic [10:0] M_ASUB = 11'h004;
    localparam logic [10:0] M_HALT = 11'h001;

    localparam logic [2:0] T_NOP = 3'd0, T_LDA = 3'd1, T_STA = 3'd2, T_ADD = 3'd3,
                           T_SUB = 3'd4, T_JMP = 3'd5, T_JZ  = 3'd6, T_HLT = 3'd7;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          RUN;
    logic [2:0]    IR_OP;
    logic          ZERO;
    logic          MEM_ACK;
    logic          HIR, HPC, LPC, SEL_MAR, HMAR, MEM_RD, MEM_WR, HACC, HALTED;
    logic [1:0]    ALU_OP;
    logic [CW-1:0] INSTR_COUNT;
    logic [10:0]   obs;

    control_unit #(.DATA_W(8), .OP_W(3), .CNT_W(CW)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .RUN         (RUN),
        .IR_OP       (IR_OP),
        .ZERO        (ZERO),
        .MEM_ACK     (MEM_ACK),
        .HIR         (HIR),
        .HPC         (HPC),
        .LPC         (LPC),
        .SEL_MAR     (SEL_MAR),
        .HMAR        (HMAR),
        .MEM_RD      (MEM_RD),
        .MEM_WR      (MEM_WR),
        .HACC        (HACC),
        .ALU_OP      (ALU_OP),
        .HALTED      (HALTED),
        .INSTR_COUNT (INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    assign obs = {HIR, HPC, LPC, SEL_MAR, HMAR, MEM_RD, MEM_WR, HACC, ALU_OP, HALTED};

    typedef struct {
        string       tag;
        bit          ack_rand;
        bit          ack;
        bit          is_dec;
        bit [2:0]    op;
        bit          zero;
        logic [10:0] exp;
    } rec_t;

    rec_t  q[$];
    int    total = 0;
    int    bad   = 0;
    int    cnt_exp = 0;
    string names[8] = '{"NOP", "LDA", "STA", "ADD", "SUB", "JMP", "JZ", "HLT"};

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push_instr(input bit [2:0] op, input bit zero, input int wf, input int we);
        rec_t r;
        bit   mem_op;
        mem_op = (op == T_LDA) || (op == T_STA) || (op == T_ADD) || (op == T_SUB);
        r.tag = {names[op], " f_addr"};
        r.ack_rand = 1'b1; r.ack = 1'b0; r.is_dec = 1'b0; r.op = op; r.zero = zero;
        r.exp = M_HMAR;
        q.push_back(r);
        for (int i = 0; i <= wf; i++) begin
            r.tag = $sformatf("%s f_read%0d", names[op], i);
            r.ack_rand = 1'b0;
            r.ack = (i == wf);
            r.exp = r.ack ? (M_RD | M_HIR | M_HPC) : M_RD;
            q.push_back(r);
        end
        r.tag = {names[op], " decode"};
        r.ack_rand = 1'b1; r.ack = 1'b0; r.is_dec = 1'b1;
        if (op == T_JMP || (op == T_JZ && zero)) r.exp = M_LPC;
        else if (mem_op)                         r.exp = M_SEL | M_HMAR;
        else                                     r.exp = 11'h000;
        q.push_back(r);
        r.is_dec = 1'b0;
        if (mem_op) begin
            for (int i = 0; i <= we; i++) begin
                r.tag = $sformatf("%s exec%0d", names[op], i);
                r.ack_rand = 1'b0;
                r.ack = (i == we);
                r.exp = (op == T_STA) ? M_WR : M_RD;
                if (r.ack && op == T_LDA) r.exp = r.exp | M_HACC;
                if (r.ack && op == T_ADD) r.exp = r.exp | M_HACC | M_AADD;
                if (r.ack && op == T_SUB) r.exp = r.exp | M_HACC | M_ASUB;
                q.push_back(r);
            end
        end
    endtask

    task automatic step_one();
        rec_t r;
        r = q.pop_front();
        @(negedge CLK);
        RUN     = 1'($urandom);
        MEM_ACK = r.ack_rand ? 1'($urandom) : r.ack;
        IR_OP   = r.is_dec ? r.op : 3'($urandom);
        ZERO    = r.is_dec ? r.zero : 1'($urandom);
        #1;
        check(r.tag, 32'(obs), 32'(r.exp));
        check({r.tag, " count"}, 32'(INSTR_COUNT), 32'(cnt_exp % 16));
        check({r.tag, " rd_wr_excl"}, 32'(MEM_RD & MEM_WR), 32'(0));
        @(posedge CLK);
        if (r.is_dec) cnt_exp++;
    endtask

    task automatic run_all();
        while (q.size() > 0) step_one();
    endtask

    task automatic idle_cycle(input bit run);
        @(negedge CLK);
        RUN = run; MEM_ACK = 1'($urandom); IR_OP = 3'($urandom); ZERO = 1'($urandom);
        #1;
        check("idle strobes", 32'(obs), 32'(0));
        check("idle count", 32'(INSTR_COUNT), 32'(cnt_exp % 16));
    endtask

    task automatic do_reset();
        RESET_N = 1'b0; RUN = 1'b0; MEM_ACK = 1'b0; IR_OP = 3'd0; ZERO = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("in reset strobes", 32'(obs), 32'(0));
        check("in reset count", 32'(INSTR_COUNT), 32'(0));
        @(negedge CLK);
        RESET_N = 1'b1;
        cnt_exp = 0;
    endtask

    initial begin
        do_reset();
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // NOP loop, zero wait
        push_instr(T_NOP, 1'b0, 0, 0);
        push_instr(T_NOP, 1'b0, 0, 0);
        run_all();

        // LDA 0x25 with two operand wait cycles
        push_instr(T_LDA, 1'b0, 0, 2);
        run_all();

        push_instr(T_STA, 1'b0, 1, 1);
        push_instr(T_ADD, 1'b0, 0, 0);
        push_instr(T_SUB, 1'b1, 2, 1);
        run_all();

        push_instr(T_JZ,  1'b0, 0, 0);
        push_instr(T_JZ,  1'b1, 0, 0);
        push_instr(T_JMP, 1'b0, 1, 0);
        run_all();

        // random programme; enough retirements to wrap the 4-bit counter
        repeat (24) begin
            push_instr(3'($urandom_range(6, 0)), 1'($urandom),
                       int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
            run_all();
        end

        push_instr(T_HLT, 1'b0, 1, 0);
        run_all();
        repeat (6) begin
            @(negedge CLK);
            RUN = 1'($urandom); MEM_ACK = 1'($urandom); IR_OP = 3'($urandom); ZERO = 1'($urandom);
            #1;
            check("halt strobes", 32'(obs), 32'(M_HALT));
            check("halt count", 32'(INSTR_COUNT), 32'(cnt_exp % 16));
        end

        // reset in the middle of a long STA write
        do_reset();
        idle_cycle(1'b1);
        push_instr(T_STA, 1'b0, 0, 5);
        repeat (5) step_one();
        #1;
        check("pre-reset mem_wr", 32'(MEM_WR), 32'(1));
        check("pre-reset count", 32'(INSTR_COUNT), 32'(1));
        #2;
        RESET_N = 1'b0;
        #1;
        check("async reset strobes", 32'(obs), 32'(0));
        check("async reset count", 32'(INSTR_COUNT), 32'(0));
        q.delete();
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        cnt_exp = 0;
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        push_instr(T_ADD, 1'b0, 0, 1);
        run_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
